control_sequencer: RTL

Microcoded control unit for the 8-bit bus-based CPU. Consumes the instruction register's opcode nibble and the ALU flags. Steps through fetch and execute T-states, driving every load and output-enable strobe on the shared 8-bit bus: PC, MAR, RAM, IR, accumulator A, register B, ALU and output register. It is the only bus master selector; the datapath registers latch on the rising clock edge that ends each T-state.

---
 rtl/control_sequencer_if.sv | 40 ++++
 rtl/control_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Control-word bundle between the sequencer and the CPU datapath.
// master = sequencer side, slave = datapath / bench side.
interface control_sequencer_if;
  logic       ena;
  logic [3:0] opcode;
  logic       cf_in;
  logic       zf_in;
  logic       pc_out;
  logic       pc_inc;
  logic       pc_load;
  logic       mar_load;
  logic       ram_out;
  logic       ram_load;
  logic       ir_load;
  logic       ir_out;
  logic       a_load;
  logic       a_out;
  logic       b_load;
  logic       alu_out;
  logic       alu_sub;
  logic       out_load;
  logic       halt;
  logic [2:0] step;
  logic       flag_c;
  logic       flag_z;

  modport master (
    input  ena, opcode, cf_in, zf_in,
    output pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load,
           ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub,
           out_load, halt, step, flag_c, flag_z
  );

  modport slave (
    output ena, opcode, cf_in, zf_in,
    input  pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load,
           ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub,
           out_load, halt, step, flag_c, flag_z
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded T-state sequencer for the 8-bit bus CPU.
// Define SEQ_JUMP_EN to build JMP/JC/JZ and the flag register.
module control_sequencer (
  input logic clk,
  input logic rst,
  control_sequencer_if.master bus
);

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0] step_q, step_d;
  logic       halted_q, halted_d;
  logic       lastStep;
  logic       haltNow;
  logic       flagLatch;
  logic       active;

  assign active = bus.ena && !halted_q;

  always_comb begin
    bus.pc_out   = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.pc_load  = 1'b0;
    bus.mar_load = 1'b0;
    bus.ram_out  = 1'b0;
    bus.ram_load = 1'b0;
    bus.ir_load  = 1'b0;
    bus.ir_out   = 1'b0;
    bus.a_load   = 1'b0;
    bus.a_out    = 1'b0;
    bus.b_load   = 1'b0;
    bus.alu_out  = 1'b0;
    bus.alu_sub  = 1'b0;
    bus.out_load = 1'b0;
    lastStep     = 1'b0;
    haltNow      = 1'b0;
    flagLatch    = 1'b0;
    if (active) begin
      case (step_q)
        T0: begin
          bus.pc_out   = 1'b1;
          bus.mar_load = 1'b1;
        end
        T1: begin
          bus.ram_out = 1'b1;
          bus.ir_load = 1'b1;
          bus.pc_inc  = 1'b1;
        end
        T2: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              bus.ir_out   = 1'b1;
              bus.mar_load = 1'b1;
            end
            OP_LDI: begin
              bus.ir_out = 1'b1;
              bus.a_load = 1'b1;
              lastStep   = 1'b1;
            end
`ifdef SEQ_JUMP_EN
            OP_JMP: begin
              bus.ir_out  = 1'b1;
              bus.pc_load = 1'b1;
              lastStep    = 1'b1;
            end
            OP_JC: begin
              bus.ir_out  = 1'b1;
              bus.pc_load = bus.flag_c;
              lastStep    = 1'b1;
            end
            OP_JZ: begin
              bus.ir_out  = 1'b1;
              bus.pc_load = bus.flag_z;
              lastStep    = 1'b1;
            end
`endif
            OP_OUT: begin
              bus.a_out    = 1'b1;
              bus.out_load = 1'b1;
              lastStep     = 1'b1;
            end
            OP_HLT:  haltNow  = 1'b1;
            default: lastStep = 1'b1;
          endcase
        end
        T3: begin
          case (bus.opcode)
            OP_LDA: begin
              bus.ram_out = 1'b1;
              bus.a_load  = 1'b1;
              lastStep    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              bus.ram_out = 1'b1;
              bus.b_load  = 1'b1;
            end
            OP_STA: begin
              bus.a_out    = 1'b1;
              bus.ram_load = 1'b1;
              lastStep     = 1'b1;
            end
            default: lastStep = 1'b1;
          endcase
        end
        T4: begin
          bus.alu_out = 1'b1;
          bus.a_load  = 1'b1;
          bus.alu_sub = (bus.opcode == OP_SUB);
          flagLatch   = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB);
          lastStep    = 1'b1;
        end
        default: lastStep = 1'b1;
      endcase
    end
  end

  // HLT parks the counter at T2; only reset leaves the halted state.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (active) begin
      if (haltNow)       halted_d = 1'b1;
      else if (lastStep) step_d   = T0;
      else               step_d   = step_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

`ifdef SEQ_JUMP_EN
  logic flag_c_q, flag_z_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else if (flagLatch) begin
      flag_c_q <= bus.cf_in;
      flag_z_q <= bus.zf_in;
    end
  end

  assign bus.flag_c = flag_c_q;
  assign bus.flag_z = flag_z_q;
`else
  logic unusedFlagInputs;
  assign unusedFlagInputs = bus.cf_in ^ bus.zf_in ^ flagLatch;
  assign bus.flag_c = 1'b0;
  assign bus.flag_z = 1'b0;
`endif

  assign bus.halt = halted_q;
  assign bus.step = step_q;

endmodule
